dm_store_buf: RTL and testbench
===============================

// Module: dm_store_buf
// PURPOSE
//  Store buffer between the MEM stage and data memory dm_1k (1 KiB, byte-addressed, 32-bit little-endian port).
//  Queues sw/sb stores and drains them into dm_1k one at a time.
//  Arbitrates the single dm address port between loads and drains.
//  Forwards buffered store bytes into load data, so loads always see program-order memory.
// PARAMETERS
//  DEPTH  4   number of store entries (power of 2, 2..8)
//  AW     10  byte address width, matches dm_1k
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  st_valid   in   1   store request from MEM stage
//  st_ready   out  1   buffer can accept a store this cycle
//  st_byte    in   1   1 = sb (byte store), 0 = sw (word store)
//  st_addr    in   AW  store byte address
//  st_data    in   32  store data; sb uses [7:0]
//  st_err     out  1   1-cycle pulse: sw with st_addr>1020 was rejected
//  ld_valid   in   1   word load request
//  ld_ready   out  1   load served this cycle
//  ld_addr    in   AW  load byte address
//  ld_data    out  32  merged load data; valid when ld_valid&&ld_ready
//  dm_addr    out  AW  to dm_1k addr
//  dm_din     out  32  to dm_1k din
//  dm_we      out  1   to dm_1k we
//  dm_sbsel   out  1   to dm_1k sbsel
//  dm_dout    in   32  from dm_1k dout
//  sb_empty   out  1   no stores pending; used by the halt/sync logic
// BEHAVIOUR
//  Interface: one clock (clk); rst is synchronous and active-high; all state is updated on posedge clk.
//  - Entries: circular FIFO {addr, data, byte}; head/tail pointers; count 0..DEPTH.
//  - Push: st_valid && st_ready && !reject. st_ready = (count<DEPTH).
//    reject = !st_byte && st_addr>1020; a rejected store is dropped and st_err pulses 1 cycle.
//  - Pop occurs on the WRITE cycle. Push and pop in the same cycle leave count unchanged.
//  - FSM states and transitions:
//    IDLE -> WRITE when count>0 and (!ld_valid or count==DEPTH).
//    WRITE -> IDLE unconditionally.
//  - dm_1k latches on the rising edge of we, so dm_we must be a 1-cycle pulse, always followed by at least 1 low cycle.
//  - Max drain rate is one entry per 2 cycles.
//  - Outputs in WRITE: dm_we=1, dm_addr=head.addr, dm_din=head.data, dm_sbsel=head.byte.
//    All four are stable for the whole cycle.
//  - Outputs in IDLE: dm_we=0, dm_addr=ld_addr, dm_din=0, dm_sbsel=0.
//  - ld_ready = (state==IDLE) && !(count==DEPTH). Loads have priority over drain unless the buffer is full (anti-starvation).
//  - ld_data is combinational, 0 cycles latency. For byte k (0..3), target = (ld_addr+k) mod 2^AW:
//    byte k = the youngest valid entry covering target, else dm_dout[8k+7:8k].
//    A sb entry covers target iff addr==target. A sw entry covers addr..addr+3, each byte k' = data[8k'+7:8k'].
//  - The entry popped this cycle still counts for forwarding. A store pushed this same cycle does not.
//  - sb_empty = (count==0) && (state==IDLE).
//  - Reset values: state IDLE, count 0, head/tail 0, dm_we 0, st_err 0, st_ready 1, sb_empty 1.
//  - Reset during WRITE: the pulse ends that cycle and pending entries are discarded (not written).
// STRUCTURE
//  - dm_defs.vh (shared include): AW, state encodings S_IDLE/S_WRITE, WORD_LAST_ADDR=1020.
//  - Sub-module dm_sb_fwd: combinational byte-merge (entries, head, count, ld_addr, dm_dout -> ld_data).
//  - FIFO and FSM live in the top level.
// TESTING
//  1 rst; sw 0x010<-0x11223344, idle 4 cycles
//    -> dm_we pulses once in cycle 2, dm_addr=0x010; dm bytes 0x10..0x13 = 44 33 22 11; sb_empty=1.
//  2 sw 0x020<-0xAABBCCDD then sb 0x021<-0x55, ld 0x020 same cycle as 2nd push+1
//    -> ld_data=0xAABB55DD before any drain.
//  3 fill 4 stores while ld_valid held high
//    -> st_ready=0 at count 4; ld_ready=0; a drain starts next cycle; ld_ready returns 1 the cycle after WRITE.
//  4 back-to-back drains of 3 entries -> dm_we pattern 1,0,1,0,1; never 1 on two consecutive cycles.
//  5 sw addr 0x3FE -> st_err=1 for 1 cycle, count unchanged; sb 0x3FF<-0x77 accepted and drained.
//  6 push 2 stores, assert rst during first WRITE -> dm_we=0 next cycle, count=0, only first store (if any) in dm.

Source files
------------

// File: rtl/dm_store_buf_pkg.sv
// Shared definitions for the dm_1k store buffer: address width, FSM states and
// the word-store range check.
package dm_store_buf_pkg;

  localparam int unsigned DM_AW          = 10;
  localparam int unsigned WORD_LAST_ADDR = 1020;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } sb_state_e;

  // A word store must fit entirely inside dm_1k; byte stores always fit.
  function automatic logic word_store_reject(input logic is_byte, input int unsigned addr);
    return !is_byte && (addr > WORD_LAST_ADDR);
  endfunction

endpackage

// File: rtl/dm_store_buf_if.sv
// MEM-stage store/load port plus the dm_1k port of the store buffer.
// master = MEM stage and memory side, slave = the store buffer.
interface dm_store_buf_if #(
  parameter int unsigned AW = dm_store_buf_pkg::DM_AW
);

  logic          st_valid;
  logic          st_ready;
  logic          st_byte;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_err;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic          dm_we;
  logic          dm_sbsel;
  logic [31:0]   dm_dout;

  modport master (
    output st_valid, st_byte, st_addr, st_data, ld_valid, ld_addr, dm_dout,
    input  st_ready, st_err, ld_ready, ld_data, dm_addr, dm_din, dm_we, dm_sbsel
  );

  modport slave (
    input  st_valid, st_byte, st_addr, st_data, ld_valid, ld_addr, dm_dout,
    output st_ready, st_err, ld_ready, ld_data, dm_addr, dm_din, dm_we, dm_sbsel
  );

endinterface

// File: rtl/dm_sb_fwd.sv
// Combinational load-data merge: each load byte takes the youngest buffered
// store covering it, otherwise the byte read from dm_1k.
module dm_sb_fwd
  import dm_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = DM_AW
) (
  input  logic [AW-1:0]          ent_addr_i [DEPTH],
  input  logic [31:0]            ent_data_i [DEPTH],
  input  logic                   ent_byte_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [AW-1:0]          ld_addr_i,
  input  logic [31:0]            dm_dout_i,
  output logic [31:0]            ld_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] target;
  logic [AW-1:0] off;
  logic [PW-1:0] idx;

  // Entries are scanned oldest to youngest so the last hit wins.
  always_comb begin
    ld_data_o = dm_dout_i;
    target    = '0;
    off       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      target = ld_addr_i + AW'(k);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head_i + PW'(i);
        off = target - ent_addr_i[idx];
        if (CW'(i) < count_i) begin
          if (ent_byte_i[idx]) begin
            if (off == '0) ld_data_o[8*k +: 8] = ent_data_i[idx][7:0];
          end else if (off < AW'(4)) begin
            ld_data_o[8*k +: 8] = ent_data_i[idx][8*off[1:0] +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dm_store_buf.sv
// Store buffer in front of dm_1k: queues sw/sb stores, drains them one per two
// cycles, arbitrates the dm port with loads and forwards buffered bytes.
module dm_store_buf
  import dm_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = DM_AW
) (
  input  logic          clk,
  input  logic          rst,
  dm_store_buf_if.slave bus,
  output logic          sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_state_e     state_q;
  logic          dm_we_q;
  logic          st_err_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic          ent_byte_q [DEPTH];

  logic          full;
  logic          reject;
  logic          push;
  logic          pop;
  logic [31:0]   ld_data;

  assign full   = (count_q == CW'(DEPTH));
  assign reject = word_store_reject(bus.st_byte, 32'(bus.st_addr));
  assign push   = bus.st_valid && !full && !reject;
  assign pop    = (state_q == S_WRITE);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= bus.st_addr;
      ent_data_q[tail_q] <= bus.st_data;
      ent_byte_q[tail_q] <= bus.st_byte;
    end
  end

  // Drain FSM; WRITE always lasts one cycle so dm_we is a lone pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dm_we_q  <= 1'b0;
      st_err_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      st_err_q <= bus.st_valid && !full && reject;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      case (state_q)
        S_IDLE: begin
          if ((count_q != '0) && (!bus.ld_valid || full)) begin
            state_q <= S_WRITE;
            dm_we_q <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          dm_we_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          dm_we_q <= 1'b0;
        end
      endcase
    end
  end

  dm_sb_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .ent_addr_i (ent_addr_q),
    .ent_data_i (ent_data_q),
    .ent_byte_i (ent_byte_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .ld_addr_i  (bus.ld_addr),
    .dm_dout_i  (bus.dm_dout),
    .ld_data_o  (ld_data)
  );

  assign bus.ld_data  = ld_data;
  assign bus.st_ready = !full;
  assign bus.st_err   = st_err_q;
  assign bus.ld_ready = (state_q == S_IDLE) && !full;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_addr  = pop ? ent_addr_q[head_q] : bus.ld_addr;
  assign bus.dm_din   = pop ? ent_data_q[head_q] : '0;
  assign bus.dm_sbsel = pop ? ent_byte_q[head_q] : 1'b0;
  assign sb_empty     = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_dm_store_buf.sv
// Directed bench for dm_store_buf with a behavioural dm_1k byte memory.
module tb_dm_store_buf;

  logic clk = 1'b0;
  logic rst;
  logic sb_empty;
  logic mem_clr;

  logic [7:0] mem [1024];
  logic       prev_we;
  logic       b2b;

  int n_chk  = 0;
  int n_pass = 0;

  dm_store_buf_if #(.AW(10)) bus ();

  dm_store_buf #(.DEPTH(4), .AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sb_empty (sb_empty)
  );

  always #5 clk = ~clk;

  logic [9:0] ra0, ra1, ra2, ra3;
  always_comb begin
    ra0 = bus.dm_addr;
    ra1 = bus.dm_addr + 10'd1;
    ra2 = bus.dm_addr + 10'd2;
    ra3 = bus.dm_addr + 10'd3;
    bus.dm_dout = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      prev_we <= 1'b0;
      b2b     <= 1'b0;
    end else begin
      if (bus.dm_we) begin
        mem[ra0] <= bus.dm_din[7:0];
        if (!bus.dm_sbsel) begin
          mem[ra1] <= bus.dm_din[15:8];
          mem[ra2] <= bus.dm_din[23:16];
          mem[ra3] <= bus.dm_din[31:24];
        end
      end
      prev_we <= bus.dm_we;
      if (bus.dm_we && prev_we) b2b <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic v, input logic b, input logic [9:0] a, input logic [31:0] d);
    bus.st_valid = v;
    bus.st_byte  = b;
    bus.st_addr  = a;
    bus.st_data  = d;
    #1;
  endtask

  task automatic ld(input logic v, input logic [9:0] a);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    #1;
  endtask

  task automatic wait_empty(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!sb_empty && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, sb_empty}, 32'd1);
  endtask

  logic [6:0] we_pat;
  logic [9:0] drain_addr [3];

  initial begin
    rst     = 1'b1;
    mem_clr = 1'b1;
    st(1'b0, 1'b0, 10'h000, 32'h0);
    ld(1'b0, 10'h000);
    repeat (3) step();
    rst     = 1'b0;
    mem_clr = 1'b0;
    #1;
    chk("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
    chk("rst_st_err", {31'd0, bus.st_err}, 32'd0);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);

    // single sw drains two cycles after the push
    st(1'b1, 1'b0, 10'h010, 32'h11223344);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_we_%0d", i), {31'd0, bus.dm_we}, (i == 1) ? 32'd1 : 32'd0);
      if (i == 1) begin
        chk("t1_dm_addr", {22'd0, bus.dm_addr}, 32'h010);
        chk("t1_dm_din", bus.dm_din, 32'h11223344);
        chk("t1_dm_sbsel", {31'd0, bus.dm_sbsel}, 32'd0);
      end
      step();
    end
    ld(1'b1, 10'h010);
    chk("t1_ld_mem", bus.ld_data, 32'h11223344);
    chk("t1_mem10", {24'd0, mem[16]}, 32'h44);
    chk("t1_mem13", {24'd0, mem[19]}, 32'h11);
    chk("t1_sb_empty", {31'd0, sb_empty}, 32'd1);

    // forwarding: sb overrides one byte of an older sw
    ld(1'b1, 10'h020);
    st(1'b1, 1'b0, 10'h020, 32'hAABBCCDD);
    step();
    st(1'b1, 1'b1, 10'h021, 32'h00000055);
    chk("t2_same_cycle_push", bus.ld_data, 32'hAABBCCDD);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    chk("t2_fwd_merge", bus.ld_data, 32'hAABB55DD);
    chk("t2_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    ld(1'b1, 10'h021);
    chk("t2_fwd_021", bus.ld_data, 32'h00AABB55);
    ld(1'b1, 10'h01E);
    chk("t2_fwd_01e", bus.ld_data, 32'h55DD0000);
    ld(1'b0, 10'h000);
    wait_empty("t2_drain_timeout", 20);
    ld(1'b1, 10'h020);
    chk("t2_mem", bus.ld_data, 32'hAABB55DD);

    // fill while loads pending, then anti-starvation drain
    ld(1'b1, 10'h200);
    st(1'b1, 1'b0, 10'h100, 32'hA0A1A2A3);
    step();
    st(1'b1, 1'b0, 10'h104, 32'hB0B1B2B3);
    step();
    st(1'b1, 1'b0, 10'h108, 32'hC0C1C2C3);
    step();
    st(1'b1, 1'b1, 10'h10C, 32'h000000D5);
    chk("t3_ready_cnt3", {31'd0, bus.st_ready}, 32'd1);
    chk("t3_no_drain_ld", {31'd0, bus.dm_we}, 32'd0);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    chk("t3_full_st_ready", {31'd0, bus.st_ready}, 32'd0);
    chk("t3_full_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("t3_full_we", {31'd0, bus.dm_we}, 32'd0);
    step();
    chk("t3_drain_we", {31'd0, bus.dm_we}, 32'd1);
    chk("t3_drain_addr", {22'd0, bus.dm_addr}, 32'h100);
    chk("t3_write_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    step();
    chk("t3_after_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("t3_after_st_ready", {31'd0, bus.st_ready}, 32'd1);

    ld(1'b0, 10'h000);
    we_pat        = 7'b0101010;
    drain_addr[0] = 10'h104;
    drain_addr[1] = 10'h108;
    drain_addr[2] = 10'h10C;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t4_we_%0d", i), {31'd0, bus.dm_we}, {31'd0, we_pat[6-i]});
      if (we_pat[6-i]) begin
        chk($sformatf("t4_addr_%0d", i), {22'd0, bus.dm_addr}, {22'd0, drain_addr[i/2]});
        chk($sformatf("t4_sbsel_%0d", i), {31'd0, bus.dm_sbsel}, (i == 5) ? 32'd1 : 32'd0);
      end
      step();
    end
    chk("t4_sb_empty", {31'd0, sb_empty}, 32'd1);
    ld(1'b1, 10'h10C);
    chk("t4_mem_sb", bus.ld_data, 32'h000000D5);
    ld(1'b1, 10'h104);
    chk("t4_mem_sw", bus.ld_data, 32'hB0B1B2B3);
    ld(1'b0, 10'h000);

    // word-store range check and address wrap
    st(1'b1, 1'b0, 10'h3FE, 32'hDEADBEEF);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    chk("t5_err_pulse", {31'd0, bus.st_err}, 32'd1);
    chk("t5_err_empty", {31'd0, sb_empty}, 32'd1);
    step();
    chk("t5_err_end", {31'd0, bus.st_err}, 32'd0);
    ld(1'b1, 10'h3FC);
    st(1'b1, 1'b0, 10'h3FC, 32'h01020304);
    step();
    st(1'b1, 1'b1, 10'h3FF, 32'h00000077);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    chk("t5_edge_no_err", {31'd0, bus.st_err}, 32'd0);
    chk("t5_fwd_3fc", bus.ld_data, 32'h77020304);
    ld(1'b1, 10'h3FE);
    chk("t5_fwd_3fe_wrap", bus.ld_data, 32'h00007702);
    ld(1'b1, 10'h3FF);
    chk("t5_fwd_3ff_wrap", bus.ld_data, 32'h00000077);
    ld(1'b0, 10'h000);
    wait_empty("t5_drain_timeout", 20);
    ld(1'b1, 10'h3FC);
    chk("t5_mem_3fc", bus.ld_data, 32'h77020304);
    ld(1'b0, 10'h000);

    // reset during the first WRITE discards the rest
    st(1'b1, 1'b0, 10'h040, 32'hCAFEF00D);
    step();
    st(1'b1, 1'b0, 10'h044, 32'h12345678);
    step();
    st(1'b0, 1'b0, 10'h000, 32'h0);
    chk("t6_write_we", {31'd0, bus.dm_we}, 32'd1);
    chk("t6_write_addr", {22'd0, bus.dm_addr}, 32'h040);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, bus.dm_we}, 32'd0);
    chk("t6_rst_empty", {31'd0, sb_empty}, 32'd1);
    chk("t6_rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_quiet_%0d", i), {31'd0, bus.dm_we}, 32'd0);
    end
    ld(1'b1, 10'h040);
    chk("t6_mem_first", bus.ld_data, 32'hCAFEF00D);
    ld(1'b1, 10'h044);
    chk("t6_mem_second", bus.ld_data, 32'h00000000);
    ld(1'b0, 10'h000);

    chk("we_never_b2b", {31'd0, b2b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
